// File: rtl/mux_rr_pipe_if.sv
// Handshake bundle between the N-channel source side and the single-output mux.
// IN_DATA is flattened: channel i occupies bits [i*WIDTH +: WIDTH].
interface mux_rr_pipe_if #(
  parameter int WIDTH = 32,
  parameter int N     = 8
);
  localparam int SELW = $clog2(N);

  logic                 EN;
  logic                 MODE;
  logic [SELW-1:0]      SEL;
  logic [N*WIDTH-1:0]   IN_DATA;
  logic [N-1:0]         IN_VALID;
  logic [N-1:0]         IN_READY;
  logic [WIDTH-1:0]     OUT_DATA;
  logic [SELW-1:0]      OUT_SEL;
  logic                 OUT_VALID;
  logic                 OUT_READY;
  logic [15:0]          XFER_CNT;

  modport master (
    output EN, MODE, SEL, IN_DATA, IN_VALID, OUT_READY,
    input  IN_READY, OUT_DATA, OUT_SEL, OUT_VALID, XFER_CNT
  );

  modport slave (
    input  EN, MODE, SEL, IN_DATA, IN_VALID, OUT_READY,
    output IN_READY, OUT_DATA, OUT_SEL, OUT_VALID, XFER_CNT
  );
endinterface

// File: rtl/mux_rr_pipe.sv
// N:1 registered mux with per-channel valid/ready, external-select or round-robin
// grant, a single output register and an accepted-transfer counter.
module mux_rr_pipe #(
  parameter int WIDTH = 32,
  parameter int N     = 8
) (
  input  logic         CLK,
  input  logic         RSTn,
  mux_rr_pipe_if.slave bus
);
  localparam int SELW = $clog2(N);

  logic [N-1:0][WIDTH-1:0] din;
  logic [SELW-1:0]         ptr;
  logic [SELW-1:0]         g;
  logic                    gnt_vld;
  logic                    space;
  logic                    accept;
  logic [2*N-1:0]          rot;
  logic [SELW:0]           sum;

  logic [WIDTH-1:0]        out_data;
  logic [SELW-1:0]         out_sel;
  logic                    out_valid;
  logic [15:0]             xfer_cnt;

  assign din   = bus.IN_DATA;
  assign space = !out_valid || bus.OUT_READY;

  // Round-robin scans a doubled valid vector rotated by ptr, so the first set
  // bit at offset k maps back to channel (ptr+k) mod N for any N.
  always_comb begin
    g       = '0;
    gnt_vld = 1'b0;
    sum     = '0;
    rot     = {bus.IN_VALID, bus.IN_VALID} >> ptr;
    if (!bus.MODE) begin
      for (int i = 0; i < N; i++) begin
        if (bus.SEL == SELW'(i) && bus.IN_VALID[i]) begin
          g       = SELW'(i);
          gnt_vld = 1'b1;
        end
      end
    end else begin
      for (int k = N - 1; k >= 0; k--) begin
        if (rot[k]) begin
          sum = {1'b0, ptr} + (SELW+1)'(k);
          if (sum >= (SELW+1)'(N)) sum = sum - (SELW+1)'(N);
          g       = sum[SELW-1:0];
          gnt_vld = 1'b1;
        end
      end
    end
  end

  assign accept = RSTn && bus.EN && space && gnt_vld;

  for (genvar i = 0; i < N; i++) begin : g_rdy
    assign bus.IN_READY[i] = accept && (g == SELW'(i));
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      out_data  <= '0;
      out_sel   <= '0;
      out_valid <= 1'b0;
      xfer_cnt  <= '0;
      ptr       <= '0;
    end else if (accept) begin
      out_data  <= din[g];
      out_sel   <= g;
      out_valid <= 1'b1;
      xfer_cnt  <= xfer_cnt + 16'd1;
      if (bus.MODE) ptr <= (g == SELW'(N-1)) ? '0 : g + 1'b1;
    end else if (space) begin
      out_valid <= 1'b0;
    end
  end

  assign bus.OUT_DATA  = out_data;
  assign bus.OUT_SEL   = out_sel;
  assign bus.OUT_VALID = out_valid;
  assign bus.XFER_CNT  = xfer_cnt;
endmodule

// File: tb/tb_mux_rr_pipe.sv
// Directed bench for mux_rr_pipe: an 8-channel instance for the main flow and a
// 6-channel instance for out-of-range selects; a negedge monitor drains expectations.
module tb_mux_rr_pipe;
  logic CLK = 1'b0;
  logic RSTn = 1'b0;
  always #5 CLK = ~CLK;

  mux_rr_pipe_if #(.WIDTH(32), .N(8)) b8();
  mux_rr_pipe_if #(.WIDTH(32), .N(6)) b6();

  mux_rr_pipe #(.WIDTH(32), .N(8)) dut8 (.CLK(CLK), .RSTn(RSTn), .bus(b8.slave));
  mux_rr_pipe #(.WIDTH(32), .N(6)) dut6 (.CLK(CLK), .RSTn(RSTn), .bus(b6.slave));

  typedef struct {
    logic [2:0]  sel;
    logic [31:0] data;
  } exp_t;

  exp_t q8[$];
  exp_t q6[$];
  exp_t x8, x6;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t e(input int ch, input int base);
    exp_t r;
    r.sel  = 3'(ch);
    r.data = 32'(base + ch);
    return r;
  endfunction

  // Every consumed word must match the oldest expected grant.
  always @(negedge CLK) begin
    if (RSTn && b8.OUT_VALID && b8.OUT_READY) begin
      if (q8.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL out8_extra: got sel %0d data %0d, expected no word", b8.OUT_SEL, b8.OUT_DATA);
      end else begin
        x8 = q8.pop_front();
        chk("out8_sel", 32'(b8.OUT_SEL), 32'(x8.sel));
        chk("out8_data", b8.OUT_DATA, x8.data);
      end
    end
    if (RSTn && b6.OUT_VALID && b6.OUT_READY) begin
      if (q6.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL out6_extra: got sel %0d data %0d, expected no word", b6.OUT_SEL, b6.OUT_DATA);
      end else begin
        x6 = q6.pop_front();
        chk("out6_sel", 32'(b6.OUT_SEL), 32'(x6.sel));
        chk("out6_data", b6.OUT_DATA, x6.data);
      end
    end
  end

  initial begin
    b8.EN = 1'b1; b8.MODE = 1'b0; b8.SEL = '0; b8.IN_VALID = 8'hff; b8.OUT_READY = 1'b1;
    for (int i = 0; i < 8; i++) b8.IN_DATA[i*32 +: 32] = 32'(10 + i);
    b6.EN = 1'b0; b6.MODE = 1'b0; b6.SEL = '0; b6.IN_VALID = 6'h3f; b6.OUT_READY = 1'b1;
    for (int i = 0; i < 6; i++) b6.IN_DATA[i*32 +: 32] = 32'(20 + i);

    // reset held with everything valid
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_out_valid", 32'(b8.OUT_VALID), 32'd0);
    chk("rst_out_data", b8.OUT_DATA, 32'd0);
    chk("rst_in_ready", 32'(b8.IN_READY), 32'd0);
    chk("rst_xfer_cnt", 32'(b8.XFER_CNT), 32'd0);
    #1 b8.EN = 1'b0; RSTn = 1'b1;
    repeat (2) begin
      @(negedge CLK);
      chk("idle_en0_ready", 32'(b8.IN_READY), 32'd0);
      chk("idle_en0_valid", 32'(b8.OUT_VALID), 32'd0);
    end

    // select sweep, back-to-back
    @(posedge CLK); #1 b8.EN = 1'b1;
    for (int i = 0; i < 8; i++) begin
      b8.SEL = 3'(i);
      q8.push_back(e(i, 10));
      @(negedge CLK);
      chk("sweep_ready", 32'(b8.IN_READY), 32'(1 << i));
      @(posedge CLK); #1;
    end
    b8.EN = 1'b0;
    @(negedge CLK);
    chk("sweep_xfer_cnt", 32'(b8.XFER_CNT), 32'd8);

    // round-robin over all channels, then channels 2 and 5 only
    @(posedge CLK); #1 b8.MODE = 1'b1; b8.EN = 1'b1;
    for (int k = 0; k < 16; k++) begin
      q8.push_back(e(k % 8, 10));
      @(negedge CLK);
      chk("rr_ready", 32'(b8.IN_READY), 32'(1 << (k % 8)));
      @(posedge CLK); #1;
    end
    b8.IN_VALID = 8'h24;
    for (int k = 0; k < 4; k++) begin
      q8.push_back(e((k % 2 == 0) ? 2 : 5, 10));
      @(negedge CLK);
      chk("rr25_ready", 32'(b8.IN_READY), (k % 2 == 0) ? 32'h04 : 32'h20);
      @(posedge CLK); #1;
    end
    b8.EN = 1'b0; b8.IN_VALID = 8'hff;

    // backpressure with word 14 held, then no-bubble reload
    @(posedge CLK); #1 b8.MODE = 1'b0; b8.SEL = 3'd4; b8.OUT_READY = 1'b0; b8.EN = 1'b1;
    q8.push_back(e(4, 10));
    @(posedge CLK);
    repeat (3) begin
      @(negedge CLK);
      chk("bp_hold_data", b8.OUT_DATA, 32'd14);
      chk("bp_hold_valid", 32'(b8.OUT_VALID), 32'd1);
      chk("bp_hold_ready", 32'(b8.IN_READY), 32'd0);
      @(posedge CLK);
    end
    #1 b8.SEL = 3'd5; b8.OUT_READY = 1'b1;
    q8.push_back(e(5, 10));
    @(negedge CLK);
    chk("bp_release_ready", 32'(b8.IN_READY), 32'h20);
    @(posedge CLK); #1 b8.EN = 1'b0;
    @(negedge CLK);
    chk("bp_nobubble_valid", 32'(b8.OUT_VALID), 32'd1);

    // EN falls with a word held: it drains, nothing new accepted
    @(posedge CLK); #1 b8.MODE = 1'b1; b8.EN = 1'b1; b8.OUT_READY = 1'b0;
    q8.push_back(e(6, 10));
    @(posedge CLK); #1 b8.EN = 1'b0; b8.OUT_READY = 1'b1;
    @(negedge CLK);
    chk("en0_ready", 32'(b8.IN_READY), 32'd0);
    chk("en0_held_valid", 32'(b8.OUT_VALID), 32'd1);
    @(posedge CLK);
    @(negedge CLK);
    chk("en0_drained_valid", 32'(b8.OUT_VALID), 32'd0);
    chk("en0_xfer_cnt", 32'(b8.XFER_CNT), 32'd31);

    // async reset mid-stream; pointer restarts at channel 0
    @(posedge CLK); #1 b8.EN = 1'b1;
    q8.push_back(e(7, 10));
    @(posedge CLK);
    q8.push_back(e(0, 10));
    @(posedge CLK);
    @(negedge CLK); #1 RSTn = 1'b0;
    #1;
    chk("arst_valid", 32'(b8.OUT_VALID), 32'd0);
    chk("arst_xfer_cnt", 32'(b8.XFER_CNT), 32'd0);
    chk("arst_ready", 32'(b8.IN_READY), 32'd0);
    q8.push_back(e(0, 10));
    #1 RSTn = 1'b1;
    @(posedge CLK); #1 b8.EN = 1'b0;
    @(negedge CLK);
    chk("arst_restart_cnt", 32'(b8.XFER_CNT), 32'd1);

    // six channels: SEL=7 and SEL=6 never grant
    @(posedge CLK); #1 b6.SEL = 3'd3; b6.EN = 1'b1; b6.OUT_READY = 1'b0;
    q6.push_back(e(3, 20));
    @(posedge CLK); #1 b6.SEL = 3'd7;
    @(negedge CLK);
    chk("n6_sel7_ready", 32'(b6.IN_READY), 32'd0);
    chk("n6_held_valid", 32'(b6.OUT_VALID), 32'd1);
    @(posedge CLK); #1 b6.SEL = 3'd6;
    @(negedge CLK);
    chk("n6_sel6_ready", 32'(b6.IN_READY), 32'd0);
    @(posedge CLK); #1 b6.OUT_READY = 1'b1;
    @(negedge CLK);
    chk("n6_space_ready", 32'(b6.IN_READY), 32'd0);
    @(posedge CLK); #1 b6.SEL = 3'd7;
    @(negedge CLK);
    chk("n6_drained_valid", 32'(b6.OUT_VALID), 32'd0);
    chk("n6_drained_ready", 32'(b6.IN_READY), 32'd0);
    chk("n6_xfer_cnt", 32'(b6.XFER_CNT), 32'd1);
    @(posedge CLK); #1 b6.SEL = 3'd5;
    q6.push_back(e(5, 20));
    @(negedge CLK);
    chk("n6_sel5_ready", 32'(b6.IN_READY), 32'h20);
    @(posedge CLK); #1 b6.EN = 1'b0;

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("q8_drained", 32'(q8.size()), 32'd0);
    chk("q6_drained", 32'(q6.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
